// File: rtl/mips_pkg.sv
// Shared MIPS definitions: canonical NOP, primary opcodes and the bit
// positions of the decoded control-line vector used by later stages.
package mips_pkg;

    // SLL $0,$0,0 -- the instruction placed in a flushed or empty slot
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Primary opcode field values (instr[31:26])
    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;

    // Bit indices into the ControlLines vector produced by decode
    localparam int CL_REGDST   = 0;
    localparam int CL_JUMP     = 1;
    localparam int CL_BRANCH   = 2;
    localparam int CL_MEMREAD  = 3;
    localparam int CL_MEMTOREG = 4;
    localparam int CL_ALUOP_LO = 5;
    localparam int CL_ALUOP_HI = 8;
    localparam int CL_MEMWRITE = 9;
    localparam int CL_ALUSRC   = 10;
    localparam int CL_REGWRITE = 11;
    localparam int CL_WIDTH    = 12;

endpackage : mips_pkg

// File: rtl/instr_mem.sv
// Read-only instruction memory with a combinational read port.
// The image is supplied as a flat parameter vector (word i at bits
// [32*i +: 32]) so it is fixed at elaboration and never written at run time.
// Any word address beyond the populated depth returns the canonical NOP.
module instr_mem
    import mips_pkg::*;
#(
    parameter int                          IMEM_DEPTH = 256,
    parameter logic [32*IMEM_DEPTH-1:0]    IMEM_INIT  = '0
) (
    input  logic [29:0] word_addr_i,   // byte address bits [31:2]
    output logic [31:0] instr_o
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [AW-1:0] index;
    logic          in_range;

    assign index    = word_addr_i[AW-1:0];
    assign in_range = (word_addr_i[29:AW] == '0);

    // Combinational ROM lookup; upper address bits must be zero to hit
    always_comb begin
        instr_o = NOP_INSTR;
        if (in_range) begin
            instr_o = IMEM_INIT[32*index +: 32];
        end
    end

endmodule : instr_mem

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and loads
// the IF/ID boundary {Instruction, PCPlus4, Valid} consumed by decode.
// Next-PC priority each edge: jump, then branch, then stall, then PC+4.
// A redirect always flushes the IF/ID slot to a NOP bubble, even if Stall
// is asserted in the same cycle.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0]                 RESET_PC   = 32'h0000_0000,
    parameter int                          IMEM_DEPTH = 256,
    parameter logic [32*IMEM_DEPTH-1:0]    IMEM_INIT  = '0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic        JumpTaken,
    input  logic [31:0] RedirectBase,
    input  logic [31:0] BranchOffset,
    input  logic [25:0] JumpIndex,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        Valid
);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q,  pcp4_d;
    logic        valid_q, valid_d;

    logic [31:0] imem_instr;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    // PC[1:0] never reach the memory: fetch is always word aligned
    instr_mem #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .IMEM_INIT  (IMEM_INIT)
    ) u_imem (
        .word_addr_i (pc_q[31:2]),
        .instr_o     (imem_instr)
    );

    // All sums are modulo 2^32; the shift drops BranchOffset[31:30]
    assign pc_plus4      = pc_q + 32'd4;
    assign jump_target   = {RedirectBase[31:28], JumpIndex, 2'b00};
    assign branch_target = RedirectBase + (BranchOffset << 2);

    // Next-PC and IF/ID selection in priority order
    always_comb begin
        pc_d    = pc_plus4;
        instr_d = imem_instr;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
        if (JumpTaken) begin
            pc_d    = jump_target;
            instr_d = NOP_INSTR;
            pcp4_d  = 32'h0;
            valid_d = 1'b0;
        end else if (BranchTaken) begin
            pc_d    = branch_target;
            instr_d = NOP_INSTR;
            pcp4_d  = 32'h0;
            valid_d = 1'b0;
        end else if (Stall) begin
            pc_d    = pc_q;
            instr_d = instr_q;
            pcp4_d  = pcp4_q;
            valid_d = valid_q;
        end
    end

    // PC and IF/ID registers with asynchronous reset to an empty slot
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign PC          = pc_q;
    assign Instruction = instr_q;
    assign PCPlus4     = pcp4_q;
    assign Valid       = valid_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle control inputs with
// hand-computed PC / IF/ID results, plus hand-written reset sequences.
module tb_fetch_stage;

    localparam int DEPTH = 256;

    // Memory image: word i holds 32'h8C00_0000 | i, so every populated word
    // is non-zero and distinguishable from the NOP returned out of range.
    function automatic logic [32*DEPTH-1:0] make_init();
        logic [32*DEPTH-1:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            r[32*i +: 32] = 32'h8C00_0000 | 32'(i);
        end
        return r;
    endfunction

    localparam logic [32*DEPTH-1:0] INIT = make_init();

    function automatic logic [31:0] w(input int n);
        return 32'h8C00_0000 | 32'(n);
    endfunction

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br;
    logic        jmp;
    logic [31:0] base;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;

    int n_cmp;
    int n_bad;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (DEPTH),
        .IMEM_INIT  (INIT)
    ) dut (
        .Clk          (clk),
        .Rst          (rst),
        .Stall        (stall),
        .BranchTaken  (br),
        .JumpTaken    (jmp),
        .RedirectBase (base),
        .BranchOffset (off),
        .JumpIndex    (idx),
        .PC           (pc),
        .Instruction  (instr),
        .PCPlus4      (pcp4),
        .Valid        (valid)
    );

    // Clock: 10 time-unit period, first posedge at t=5
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic        jmp;
        logic [31:0] base;
        logic [31:0] off;
        logic [25:0] idx;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [31:0] e_p4;
        logic        e_v;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic b, input logic j,
                                input logic [31:0] ba, input logic [31:0] of,
                                input logic [25:0] ix, input logic [31:0] epc,
                                input logic [31:0] eins, input logic [31:0] ep4,
                                input logic ev);
        vec_t v;
        v.stall = s;  v.br = b;  v.jmp = j;
        v.base = ba;  v.off = of; v.idx = ix;
        v.e_pc = epc; v.e_ins = eins; v.e_p4 = ep4; v.e_v = ev;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] epc, input logic [31:0] eins,
                             input logic [31:0] ep4, input logic ev);
        check32({tag, ".pc"},    pc,    epc);
        check32({tag, ".instr"}, instr, eins);
        check32({tag, ".pcp4"},  pcp4,  ep4);
        check32({tag, ".valid"}, {31'h0, valid}, {31'h0, ev});
    endtask

    task automatic idle_inputs();
        stall = 1'b0; br = 1'b0; jmp = 1'b0;
        base = 32'h0; off = 32'h0; idx = 26'h0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle_inputs();
        rst = 1'b1;

        //             s  b  j  base          off           idx         pc            instr    pcp4          v
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd4,        w(0),    32'd4,        1)); // sequential A
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd8,        w(1),    32'd8,        1)); // B
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        26'h0,      32'd8,        w(1),    32'd8,        1)); // stall at 8
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        26'h0,      32'd8,        w(1),    32'd8,        1)); // stall again
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd12,       w(2),    32'd12,       1)); // resumes with IMEM[2]
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd16,       w(3),    32'd16,       1)); // D, PC=16
        vecs.push_back(mk(0, 1, 0, 32'd12,       32'hFFFF_FFFE,26'h0,      32'd4,        32'h0,   32'h0,        0)); // branch back
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd8,        w(1),    32'd8,        1)); // IMEM[1] after branch
        vecs.push_back(mk(1, 1, 1, 32'h1000_0004,32'd5,        26'h10,     32'h1000_0040,32'h0,   32'h0,        0)); // jump beats branch+stall
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'h1000_0044,32'h0,   32'h1000_0044,1)); // high bits set -> NOP
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'hFFFF_FFFF,26'h0,      32'hFFFF_FFFC,32'h0,   32'h0,        0)); // branch beats stall, wraps
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'h0,        32'h0,   32'h0,        1)); // PC+4 wraps to 0
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd4,        w(0),    32'd4,        1)); // fetch from 0 again
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h4000_0001,26'h0,      32'd4,        32'h0,   32'h0,        0)); // offset[31:30] discarded
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,        26'd255,    32'd1020,     32'h0,   32'h0,        0)); // jump to last word
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd1024,     w(255),  32'd1024,     1)); // last word
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd1028,     32'h0,   32'd1028,     1)); // past end -> NOP, valid
        vecs.push_back(mk(0, 0, 1, 32'hF000_0000,32'h0,        26'h3FF_FFFF,32'hFFFF_FFFC,32'h0,  32'h0,        0)); // jump to top of space
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        26'h0,      32'hFFFF_FFFC,32'h0,   32'h0,        0)); // stall holds bubble
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'h0,        32'h0,   32'h0,        1)); // wrap fetch
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd4,        w(0),    32'd4,        1));
        vecs.push_back(mk(1, 0, 1, 32'h0,        32'h0,        26'd2,      32'd8,        32'h0,   32'h0,        0)); // jump beats stall
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd12,       w(2),    32'd12,       1));
        vecs.push_back(mk(0, 1, 0, 32'd1,        32'h0,        26'h0,      32'd1,        32'h0,   32'h0,        0)); // unaligned target
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        26'h0,      32'd5,        w(0),    32'd5,        1)); // PC[1:0] ignored

        // Power-on reset held across a couple of edges
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;

        // Table: drive just after an edge, check just after the next one
        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall;
            br    = vecs[i].br;
            jmp   = vecs[i].jmp;
            base  = vecs[i].base;
            off   = vecs[i].off;
            idx   = vecs[i].idx;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_p4, vecs[i].e_v);
        end
        idle_inputs();

        // Mid-run asynchronous reset: takes effect without a clock edge
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_held", 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_release", 32'd4, w(0), 32'd4, 1'b1);
        @(posedge clk);
        #1;
        check_all("rst_release2", 32'd8, w(1), 32'd8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_stage
